// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad front end of the timer datapath.
package keypad_pkg;

  localparam int KEY_COUNT = 10;
  localparam int DIGIT_W   = 4;

  // Debounce/accept sequencing for one physical press.
  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PULSE,
    HELD,
    RELEASE_WAIT
  } state_e;

  // What the synchronized key vector looks like this cycle.
  typedef enum logic [1:0] {
    KS_NONE,
    KS_SINGLE,
    KS_MULTI
  } ks_class_e;

  // Width of a counter that must reach DEBOUNCE_CYCLES: CNT_W = $clog2(DEBOUNCE_CYCLES+1).
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Multi-stage synchronizer for a vector of asynchronous button lines.
// Generic in width so the door/start buttons can share it.
module keypad_sync
  import keypad_pkg::*;
#(
  parameter int WIDTH  = KEY_COUNT,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             clrn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  // Each stage takes the previous one; stage 0 takes the raw lines.
  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Shift the chain; every stage clears so no stale key survives reset.
  // NOTE: an array of flops is still state -- clear every element in the
  // reset branch, or a pre-reset key press can leak out after clrn rises.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking (<=) so every stage samples its neighbour's
      // old value; blocking here would collapse the chain into one flop.
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/keypad_encoder.sv
// 10-key decimal keypad front end: synchronizes and debounces the key lines,
// then emits one BCD digit with a one-clock active-low load strobe per press.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                 clock,
  input  logic                 clrn,
  input  logic [KEY_COUNT-1:0] keypad,
  output logic [DIGIT_W-1:0]   data,
  output logic                 loadn,
  output logic                 key_held
);

  localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [KEY_COUNT-1:0] ks;
  logic [KEY_COUNT-1:0] ks_prev_q;
  ks_class_e            ks_class;
  logic [DIGIT_W-1:0]   ks_digit;
  logic                 stable;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  state_e               state_q, state_d;
  logic [DIGIT_W-1:0]   data_q, data_d;
  logic                 loadn_q, loadn_d;
  logic                 key_held_q, key_held_d;

  keypad_sync #(
    .WIDTH  (KEY_COUNT),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .clrn  (clrn),
    .din   (keypad),
    .dout  (ks)
  );

  // Classify the synchronized vector and encode the lone set bit, if any.
  // NOTE: every output gets a default at the top so no path leaves one
  // unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    ks_class = KS_MULTI;
    ks_digit = '0;
    if (ks == '0) begin
      ks_class = KS_NONE;
    end else if ((ks & (ks - KEY_COUNT'(1))) == '0) begin
      ks_class = KS_SINGLE;
    end
    for (int i = 0; i < KEY_COUNT; i++) begin
      if (ks[i]) begin
        ks_digit = DIGIT_W'(i);
      end
    end
  end

  // Count how long ks has held unchanged, saturating at the debounce length.
  always_comb begin
    if (ks != ks_prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign stable = (cnt_q == CNT_MAX);

  // Press/release sequencing; outputs are decoded from the next state so they
  // come straight out of flops.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ks_class == KS_SINGLE) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (ks_class == KS_NONE)                 state_d = IDLE;
        else if (ks_class == KS_SINGLE && stable) state_d = PULSE;
      end
      PULSE: begin
        state_d = HELD;
      end
      HELD: begin
        // Rollover to other keys is ignored until everything is released.
        if (ks_class == KS_NONE) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (ks_class != KS_NONE) state_d = HELD;
        else if (stable)         state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    loadn_d    = (state_d != PULSE);
    key_held_d = (state_d inside {PULSE, HELD, RELEASE_WAIT});
    data_d     = (state_q == PRESS_WAIT && state_d == PULSE) ? ks_digit : data_q;
  end

  // All encoder state and registered outputs.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ks_prev_q  <= '0;
      data_q     <= '0;
      loadn_q    <= 1'b1;
      key_held_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ks_prev_q  <= ks;
      data_q     <= data_d;
      loadn_q    <= loadn_d;
      key_held_q <= key_held_d;
    end
  end

  assign data     = data_q;
  assign loadn    = loadn_q;
  assign key_held = key_held_q;

endmodule
